// File: rtl/wifire_frame_decoder.sv
// 802.15.4 receive header parser: nibbles -> bytes -> PHY length, MAC header fields, MSDU stream.
// Each field and its valid flag register on the edge sampling the final symbol; no backpressure, strobes may be back-to-back.
module wifire_frame_decoder (
    input  logic        dsp_clk,
    input  logic        reset,
    input  logic        en,
    input  logic [3:0]  rcv_sym_i,
    input  logic        rcv_sym_stb_i,
    input  logic        rcv_sfd_i,
    input  logic        rcv_running_i,
    output logic [6:0]  len_o,
    output logic [15:0] frame_ctrl_o,
    output logic [7:0]  seqno_o,
    output logic [15:0] dst_pan_o,
    output logic [15:0] src_pan_o,
    output logic [63:0] dst_addr_o,
    output logic [63:0] src_addr_o,
    output logic [7:0]  msdu_o,
    output logic [7:0]  msdu_pos_o,
    output logic        msdu_stb_o,
    output logic        valid_len_o,
    output logic        valid_frame_ctrl_o,
    output logic        valid_seqno_o,
    output logic        valid_addr_o,
    output logic        valid_msdu_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_LEN, S_FCTRL, S_SEQNO, S_DST_PAN,
        S_DST_ADDR, S_SRC_PAN, S_SRC_ADDR, S_MSDU
    } state_t;

    state_t     state;
    state_t     after_seq;
    state_t     after_dst;
    logic       nib_hi;
    logic [3:0] nib_lo;
    logic [7:0] byte_cnt;
    logic [2:0] fidx;
    logic [7:0] msdu_idx;

    logic [7:0] rx_byte;
    logic [7:0] byte_cnt_nxt;
    logic [2:0] dst_last;
    logic [2:0] src_last;

    assign rx_byte      = {rcv_sym_i, nib_lo};
    assign byte_cnt_nxt = byte_cnt + 8'd1;
    assign dst_last     = frame_ctrl_o[10] ? 3'd7 : 3'd1;
    assign src_last     = frame_ctrl_o[14] ? 3'd7 : 3'd1;

    // Address modes 0/1 are absent, so only the upper mode bit decides presence.
    always_comb begin
        after_dst = S_MSDU;
        if (frame_ctrl_o[15])
            after_dst = frame_ctrl_o[6] ? S_SRC_ADDR : S_SRC_PAN;
    end

    always_comb begin
        after_seq = after_dst;
        if (frame_ctrl_o[11])
            after_seq = S_DST_PAN;
    end

    always_ff @(posedge dsp_clk or negedge reset) begin
        if (!reset) begin
            state              <= S_IDLE;
            nib_hi             <= 1'b0;
            nib_lo             <= 4'd0;
            byte_cnt           <= 8'd0;
            fidx               <= 3'd0;
            msdu_idx           <= 8'd0;
            len_o              <= 7'd0;
            frame_ctrl_o       <= 16'd0;
            seqno_o            <= 8'd0;
            dst_pan_o          <= 16'd0;
            src_pan_o          <= 16'd0;
            dst_addr_o         <= 64'd0;
            src_addr_o         <= 64'd0;
            msdu_o             <= 8'd0;
            msdu_pos_o         <= 8'd0;
            msdu_stb_o         <= 1'b0;
            valid_len_o        <= 1'b0;
            valid_frame_ctrl_o <= 1'b0;
            valid_seqno_o      <= 1'b0;
            valid_addr_o       <= 1'b0;
            valid_msdu_o       <= 1'b0;
        end else begin
            msdu_stb_o <= 1'b0;
            if (en) begin
                if (rcv_sfd_i) begin
                    state              <= S_LEN;
                    nib_hi             <= 1'b0;
                    byte_cnt           <= 8'd0;
                    fidx               <= 3'd0;
                    msdu_idx           <= 8'd0;
                    valid_len_o        <= 1'b0;
                    valid_frame_ctrl_o <= 1'b0;
                    valid_seqno_o      <= 1'b0;
                    valid_addr_o       <= 1'b0;
                    valid_msdu_o       <= 1'b0;
                end else if (!rcv_running_i) begin
                    state  <= S_IDLE;
                    nib_hi <= 1'b0;
                end else if (rcv_sym_stb_i && state != S_IDLE) begin
                    if (!nib_hi) begin
                        nib_lo <= rcv_sym_i;
                        nib_hi <= 1'b1;
                    end else begin
                        nib_hi <= 1'b0;
                        fidx   <= fidx + 3'd1;
                        if (state != S_LEN)
                            byte_cnt <= byte_cnt_nxt;
                        case (state)
                            S_LEN: begin
                                len_o       <= rx_byte[6:0];
                                valid_len_o <= 1'b1;
                                fidx        <= 3'd0;
                                state       <= (rx_byte[6:0] == 7'd0) ? S_IDLE : S_FCTRL;
                            end
                            S_FCTRL: begin
                                if (fidx[0]) begin
                                    frame_ctrl_o[15:8] <= rx_byte;
                                    valid_frame_ctrl_o <= 1'b1;
                                    fidx               <= 3'd0;
                                    state              <= S_SEQNO;
                                end else begin
                                    frame_ctrl_o[7:0] <= rx_byte;
                                end
                            end
                            S_SEQNO: begin
                                seqno_o       <= rx_byte;
                                valid_seqno_o <= 1'b1;
                                fidx          <= 3'd0;
                                state         <= after_seq;
                                if (after_seq == S_MSDU)
                                    valid_addr_o <= 1'b1;
                                if (after_seq == S_SRC_ADDR)
                                    src_pan_o <= dst_pan_o;
                            end
                            S_DST_PAN: begin
                                if (fidx[0]) begin
                                    dst_pan_o[15:8] <= rx_byte;
                                    fidx            <= 3'd0;
                                    state           <= S_DST_ADDR;
                                end else begin
                                    dst_pan_o[7:0] <= rx_byte;
                                end
                            end
                            S_DST_ADDR: begin
                                if (fidx == 3'd0)
                                    dst_addr_o <= {56'd0, rx_byte};
                                else
                                    dst_addr_o[{fidx, 3'b000} +: 8] <= rx_byte;
                                if (fidx == dst_last) begin
                                    fidx  <= 3'd0;
                                    state <= after_dst;
                                    if (after_dst == S_MSDU)
                                        valid_addr_o <= 1'b1;
                                    if (after_dst == S_SRC_ADDR)
                                        src_pan_o <= dst_pan_o;
                                end
                            end
                            S_SRC_PAN: begin
                                if (fidx[0]) begin
                                    src_pan_o[15:8] <= rx_byte;
                                    fidx            <= 3'd0;
                                    state           <= S_SRC_ADDR;
                                end else begin
                                    src_pan_o[7:0] <= rx_byte;
                                end
                            end
                            S_SRC_ADDR: begin
                                if (fidx == 3'd0)
                                    src_addr_o <= {56'd0, rx_byte};
                                else
                                    src_addr_o[{fidx, 3'b000} +: 8] <= rx_byte;
                                if (fidx == src_last) begin
                                    fidx         <= 3'd0;
                                    state        <= S_MSDU;
                                    valid_addr_o <= 1'b1;
                                end
                            end
                            S_MSDU: begin
                                msdu_o       <= rx_byte;
                                msdu_pos_o   <= msdu_idx;
                                msdu_idx     <= msdu_idx + 8'd1;
                                msdu_stb_o   <= 1'b1;
                                valid_msdu_o <= 1'b1;
                            end
                            default: ;
                        endcase
                        // Frame length reached (FCS included): overrides any header transition.
                        if (state != S_LEN && byte_cnt_nxt == {1'b0, len_o})
                            state <= S_IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_wifire_frame_decoder.sv
// Bench for wifire_frame_decoder: directed and random frames checked byte-by-byte against an offset-based frame model.
module tb_wifire_frame_decoder;

    logic        dsp_clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  rcv_sym_i;
    logic        rcv_sym_stb_i;
    logic        rcv_sfd_i;
    logic        rcv_running_i;
    logic [6:0]  len_o;
    logic [15:0] frame_ctrl_o;
    logic [7:0]  seqno_o;
    logic [15:0] dst_pan_o, src_pan_o;
    logic [63:0] dst_addr_o, src_addr_o;
    logic [7:0]  msdu_o, msdu_pos_o;
    logic        msdu_stb_o;
    logic        valid_len_o, valid_frame_ctrl_o, valid_seqno_o, valid_addr_o, valid_msdu_o;

    wifire_frame_decoder dut (
        .dsp_clk(dsp_clk), .reset(reset), .en(en),
        .rcv_sym_i(rcv_sym_i), .rcv_sym_stb_i(rcv_sym_stb_i),
        .rcv_sfd_i(rcv_sfd_i), .rcv_running_i(rcv_running_i),
        .len_o(len_o), .frame_ctrl_o(frame_ctrl_o), .seqno_o(seqno_o),
        .dst_pan_o(dst_pan_o), .src_pan_o(src_pan_o),
        .dst_addr_o(dst_addr_o), .src_addr_o(src_addr_o),
        .msdu_o(msdu_o), .msdu_pos_o(msdu_pos_o), .msdu_stb_o(msdu_stb_o),
        .valid_len_o(valid_len_o), .valid_frame_ctrl_o(valid_frame_ctrl_o),
        .valid_seqno_o(valid_seqno_o), .valid_addr_o(valid_addr_o),
        .valid_msdu_o(valid_msdu_o)
    );

    always #5 dsp_clk = ~dsp_clk;

    int checks = 0;
    int failures = 0;

    typedef logic [7:0] bq_t[$];

    // Model of the current frame: byte list plus field offsets derived from frame control.
    bq_t         fr;
    int          flen, addr_end, dpan_at, daddr_at, span_at, saddr_at, dal, sal;
    bit          dpres, spres, panc;
    logic [15:0] fc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] le(input int at, input int nb);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = fr[at+i];
        return v;
    endfunction

    task automatic analyse();
        int p;
        logic [7:0] b0;
        b0   = fr[0];
        flen = int'(b0[6:0]);
        fc   = (fr.size() >= 3) ? {fr[2], fr[1]} : 16'd0;
        dpres = fc[11]; dal = fc[10] ? 8 : 2;
        spres = fc[15]; sal = fc[14] ? 8 : 2;
        panc  = fc[6];
        p = 4;
        dpan_at = 0; daddr_at = 0; span_at = 0; saddr_at = 0;
        if (dpres) begin dpan_at = p; daddr_at = p + 2; p += 2 + dal; end
        if (spres && !panc) begin span_at = p; p += 2; end
        if (spres) begin saddr_at = p; p += sal; end
        addr_end = p;
    endtask

    // n = bytes sent so far in this frame, lim = bytes accepted before an abort.
    task automatic check_byte(input int n, input int lim);
        int ne;
        bit m;
        ne = n;
        if (ne > flen + 1) ne = flen + 1;
        if (ne > lim) ne = lim;
        m = (n <= flen + 1) && (n <= lim) && (n - 1 >= addr_end);
        chk("valid_len", valid_len_o, 1'b1);
        chk("len", len_o, flen);
        chk("valid_fctrl", valid_frame_ctrl_o, ne >= 3);
        if (ne >= 3) chk("fctrl", frame_ctrl_o, fc);
        chk("valid_seqno", valid_seqno_o, ne >= 4);
        if (ne >= 4) chk("seqno", seqno_o, fr[3]);
        chk("valid_addr", valid_addr_o, ne >= addr_end);
        if (ne >= addr_end) begin
            if (dpres) begin
                chk("dst_pan", dst_pan_o, le(dpan_at, 2));
                chk("dst_addr", dst_addr_o, le(daddr_at, dal));
            end
            if (spres) begin
                chk("src_pan", src_pan_o, panc ? le(dpan_at, 2) : le(span_at, 2));
                chk("src_addr", src_addr_o, le(saddr_at, sal));
            end
        end
        chk("valid_msdu", valid_msdu_o, ne > addr_end);
        chk("msdu_stb", msdu_stb_o, m);
        if (m) begin
            chk("msdu", msdu_o, fr[n-1]);
            chk("msdu_pos", msdu_pos_o, n - 1 - addr_end);
        end
    endtask

    task automatic send_sym(input logic [3:0] s);
        int gap;
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) begin
            if ($urandom_range(0, 3) == 0) begin
                en = 1'b0; rcv_sym_stb_i = 1'b1; rcv_sym_i = 4'($urandom);
            end
            @(negedge dsp_clk);
            en = 1'b1; rcv_sym_stb_i = 1'b0;
        end
        rcv_sym_i = s; rcv_sym_stb_i = 1'b1;
        @(negedge dsp_clk);
        rcv_sym_stb_i = 1'b0;
    endtask

    task automatic send_sfd();
        rcv_sfd_i = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
            rcv_sym_stb_i = 1'b1; rcv_sym_i = 4'($urandom);
        end
        @(negedge dsp_clk);
        rcv_sfd_i = 1'b0; rcv_sym_stb_i = 1'b0;
        chk("sfd_valid_len", valid_len_o, 1'b0);
        chk("sfd_valid_fctrl", valid_frame_ctrl_o, 1'b0);
        chk("sfd_valid_seqno", valid_seqno_o, 1'b0);
        chk("sfd_valid_addr", valid_addr_o, 1'b0);
        chk("sfd_valid_msdu", valid_msdu_o, 1'b0);
    endtask

    task automatic run_frame(input bq_t b, input int abort_at);
        logic [7:0] bb;
        fr = b;
        analyse();
        send_sfd();
        for (int i = 0; i < fr.size(); i++) begin
            if (i == abort_at) begin
                rcv_running_i = 1'b0;
                @(negedge dsp_clk);
                rcv_running_i = 1'b1;
            end
            bb = fr[i];
            send_sym(bb[3:0]);
            send_sym(bb[7:4]);
            check_byte(i + 1, (abort_at < 0) ? 1000 : abort_at);
        end
    endtask

    initial begin
        bq_t         q;
        logic [15:0] f;
        int          hdr, l, tot, ab;

        reset = 1'b0; en = 1'b1; rcv_sym_i = 4'd0; rcv_sym_stb_i = 1'b0;
        rcv_sfd_i = 1'b0; rcv_running_i = 1'b1;
        repeat (3) @(negedge dsp_clk);
        chk("rst_len", len_o, 0);
        chk("rst_fctrl", frame_ctrl_o, 0);
        chk("rst_seqno", seqno_o, 0);
        chk("rst_pans", {dst_pan_o, src_pan_o}, 0);
        chk("rst_dst_addr", dst_addr_o, 0);
        chk("rst_src_addr", src_addr_o, 0);
        chk("rst_msdu", {msdu_o, msdu_pos_o, 7'd0, msdu_stb_o}, 0);
        chk("rst_valids", {valid_len_o, valid_frame_ctrl_o, valid_seqno_o, valid_addr_o, valid_msdu_o}, 0);
        reset = 1'b1;
        @(negedge dsp_clk);

        q = '{8'h11};
        run_frame(q, -1);
        q = '{8'h11, 8'h03, 8'h08, 8'h5a};
        run_frame(q, -1);
        q = '{8'h11, 8'h00, 8'h00, 8'h5a};
        run_frame(q, -1);
        q = '{8'h11, 8'h00, 8'h8c, 8'h21, 8'hfe, 8'hca,
              8'hbe, 8'hba, 8'hfe, 8'hca, 8'hef, 8'hbe, 8'had, 8'hde,
              8'hbe, 8'hba, 8'h5e, 8'hca};
        run_frame(q, -1);
        chk("dir_dst_addr64", dst_addr_o, 64'hdeadbeefcafebabe);
        chk("dir_src_addr16", src_addr_o, 64'h000000000000ca5e);
        q = '{8'h11, 8'h40, 8'hc8, 8'h22, 8'hfe, 8'hca, 8'hfe, 8'hfe,
              8'hef, 8'hbe, 8'had, 8'hde, 8'hbe, 8'hba, 8'hfe, 8'hca,
              8'h01, 8'h02};
        run_frame(q, -1);
        chk("dir_src_pan_panc", src_pan_o, 16'hcafe);
        chk("dir_src_addr64", src_addr_o, 64'hcafebabedeadbeef);
        q = '{8'h09, 8'h00, 8'h08, 8'h23, 8'hff, 8'hff, 8'hff, 8'hff, 8'h07, 8'hde};
        run_frame(q, -1);
        chk("dir_msdu_last", msdu_o, 8'hde);
        q = '{8'h80, 8'h12, 8'h34};
        run_frame(q, -1);
        q = '{8'h11, 8'h00, 8'h00, 8'h5a, 8'h33};
        run_frame(q, 2);

        repeat (40) begin
            q.delete();
            f = 16'($urandom);
            f[6] = f[6] & f[11];
            hdr = 3;
            if (f[11]) hdr += 2 + (f[10] ? 8 : 2);
            if (f[15] && !f[6]) hdr += 2;
            if (f[15]) hdr += f[14] ? 8 : 2;
            l = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, hdr)) : hdr + int'($urandom_range(0, 5));
            q.push_back({1'($urandom), 7'(l)});
            q.push_back(f[7:0]);
            q.push_back(f[15:8]);
            tot = l + 1 + int'($urandom_range(0, 2));
            if (tot < 3) tot = 3;
            while (q.size() < tot) q.push_back(8'($urandom));
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, tot - 1)) : -1;
            run_frame(q, ab);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
